branch_redirect_ctrl: RTL and testbench

Sequencing controller for the EX-stage branch/jump decision in the RISC-V compliance core. It accepts the branch opcode class and the one-bit taken decision from the branch/jump detector. For a taken decision it holds a redirect request to the fetch stage until fetch accepts it, then drains the wrong-path pipeline with flush pulses. While a redirect is in progress it blocks the EX stage. It also keeps saturating taken/not-taken counters for the performance CSRs.

---
 rtl/branch_redirect_ctrl.sv | 144 ++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch/jump redirect sequencer: issues a held redirect request to
// fetch on a taken decision, drains the wrong path with flush pulses, blocks
// EX while busy, and keeps saturating taken/not-taken statistics counters.
module branch_redirect_ctrl #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DRAIN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid_i,
    input  logic             pipe_stall_i,
    input  logic [2:0]       branch_jump_i,
    input  logic             pc_sel_i,
    input  logic [31:0]      target_pc_i,
    input  logic             if_ready_i,
    input  logic             cnt_clr_i,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             hold_ex_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] taken_cnt_o,
    output logic [CNT_W-1:0] ntaken_cnt_o
);

    localparam int unsigned DRAIN_W = 3;
    localparam int unsigned PC_W    = 32;
    localparam logic [2:0]  BJ_NONE = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } state_e;

    state_e             state_q;
    logic [DRAIN_W-1:0] drain_q;
    logic [PC_W-1:0]    redirect_pc_q;
    logic               redirect_valid_q;
    logic               flush_if_id_q;
    logic               flush_id_ex_q;
    logic               hold_ex_q;
    logic               misalign_q;
    logic [CNT_W-1:0]   taken_cnt_q;
    logic [CNT_W-1:0]   taken_cnt_d;
    logic [CNT_W-1:0]   ntaken_cnt_q;
    logic [CNT_W-1:0]   ntaken_cnt_d;
    logic               accept;

    // An evaluation only counts when idle, valid, unstalled and a real branch class
    assign accept = (state_q == ST_IDLE) && ex_valid_i && !pipe_stall_i
                    && (branch_jump_i != BJ_NONE);

    // Redirect sequencing FSM with registered request/flush/hold outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            drain_q          <= '0;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            flush_if_id_q    <= 1'b0;
            flush_id_ex_q    <= 1'b0;
            hold_ex_q        <= 1'b0;
            misalign_q       <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept && pc_sel_i) begin
                        state_q          <= ST_REDIRECT;
                        redirect_pc_q    <= target_pc_i & ~PC_W'(1);
                        misalign_q       <= target_pc_i[1];
                        redirect_valid_q <= 1'b1;
                        flush_if_id_q    <= 1'b1;
                        flush_id_ex_q    <= 1'b1;
                        hold_ex_q        <= 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    if (if_ready_i) begin
                        state_q          <= ST_DRAIN;
                        drain_q          <= DRAIN_W'(DRAIN_CYCLES);
                        redirect_valid_q <= 1'b0;
                        flush_id_ex_q    <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    drain_q <= drain_q - DRAIN_W'(1);
                    if (drain_q == DRAIN_W'(1)) begin
                        state_q       <= ST_IDLE;
                        flush_if_id_q <= 1'b0;
                        hold_ex_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q          <= ST_IDLE;
                    drain_q          <= '0;
                    redirect_valid_q <= 1'b0;
                    flush_if_id_q    <= 1'b0;
                    flush_id_ex_q    <= 1'b0;
                    hold_ex_q        <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics counters; clear wins over a same-cycle increment
    always_comb begin
        taken_cnt_d  = taken_cnt_q;
        ntaken_cnt_d = ntaken_cnt_q;
        if (cnt_clr_i) begin
            taken_cnt_d  = '0;
            ntaken_cnt_d = '0;
        end else if (accept) begin
            if (pc_sel_i) begin
                if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end else begin
                if (ntaken_cnt_q != '1) ntaken_cnt_d = ntaken_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q  <= '0;
            ntaken_cnt_q <= '0;
        end else begin
            taken_cnt_q  <= taken_cnt_d;
            ntaken_cnt_q <= ntaken_cnt_d;
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign flush_if_id_o    = flush_if_id_q;
    assign flush_id_ex_o    = flush_id_ex_q;
    assign hold_ex_o        = hold_ex_q;
    assign misalign_o       = misalign_q;
    assign taken_cnt_o      = taken_cnt_q;
    assign ntaken_cnt_o     = ntaken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: two instances (narrow counters / short drain,
// wide counters / longer drain) driven in lockstep and compared to a
// cycle-level behavioural model after every clock edge.
module tb_branch_redirect_ctrl;

    localparam int unsigned DR_A = 1;
    localparam int unsigned DR_B = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        pipe_stall = 1'b0;
    logic [2:0]  branch_jump = 3'b010;
    logic        pc_sel = 1'b0;
    logic [31:0] target_pc = 32'h0;
    logic        if_ready = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        rv_a, rv_b, fif_a, fif_b, fie_a, fie_b, hold_a, hold_b, mis_a, mis_b;
    logic [31:0] pc_a, pc_b;
    logic [3:0]  tk_a, ntk_a;
    logic [15:0] tk_b, ntk_b;

    branch_redirect_ctrl #(.CNT_W(4), .DRAIN_CYCLES(DR_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .pipe_stall_i(pipe_stall),
        .branch_jump_i(branch_jump), .pc_sel_i(pc_sel), .target_pc_i(target_pc),
        .if_ready_i(if_ready), .cnt_clr_i(cnt_clr),
        .redirect_valid_o(rv_a), .redirect_pc_o(pc_a), .flush_if_id_o(fif_a),
        .flush_id_ex_o(fie_a), .hold_ex_o(hold_a), .misalign_o(mis_a),
        .taken_cnt_o(tk_a), .ntaken_cnt_o(ntk_a));

    branch_redirect_ctrl #(.CNT_W(16), .DRAIN_CYCLES(DR_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .pipe_stall_i(pipe_stall),
        .branch_jump_i(branch_jump), .pc_sel_i(pc_sel), .target_pc_i(target_pc),
        .if_ready_i(if_ready), .cnt_clr_i(cnt_clr),
        .redirect_valid_o(rv_b), .redirect_pc_o(pc_b), .flush_if_id_o(fif_b),
        .flush_id_ex_o(fie_b), .hold_ex_o(hold_b), .misalign_o(mis_b),
        .taken_cnt_o(tk_b), .ntaken_cnt_o(ntk_b));

    always #5 clk = ~clk;

    // Observed outputs gathered per instance
    logic [31:0] o_rv[2], o_pc[2], o_fif[2], o_fie[2], o_hold[2], o_mis[2], o_tk[2], o_ntk[2];
    assign o_rv[0] = 32'(rv_a);     assign o_rv[1] = 32'(rv_b);
    assign o_pc[0] = pc_a;          assign o_pc[1] = pc_b;
    assign o_fif[0] = 32'(fif_a);   assign o_fif[1] = 32'(fif_b);
    assign o_fie[0] = 32'(fie_a);   assign o_fie[1] = 32'(fie_b);
    assign o_hold[0] = 32'(hold_a); assign o_hold[1] = 32'(hold_b);
    assign o_mis[0] = 32'(mis_a);   assign o_mis[1] = 32'(mis_b);
    assign o_tk[0] = 32'(tk_a);     assign o_tk[1] = 32'(tk_b);
    assign o_ntk[0] = 32'(ntk_a);   assign o_ntk[1] = 32'(ntk_b);

    // Behavioural model: a pending request flag plus a count of flush cycles left
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    bit          m_req[2];
    int unsigned m_left[2];
    int unsigned m_tk[2], m_ntk[2];
    bit          m_mis[2];
    logic [31:0] m_pc[2];
    int unsigned m_drain[2] = '{DR_A, DR_B};
    int unsigned m_max[2]   = '{15, 65535};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_req[k] = 1'b0; m_left[k] = 0; m_tk[k] = 0; m_ntk[k] = 0;
            m_mis[k] = 1'b0; m_pc[k] = 32'h0;
        end
    endtask

    task automatic model_step();
        bit acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            acc = 1'b0;
            m_mis[k] = 1'b0;
            if (m_req[k]) begin
                if (if_ready) begin
                    m_req[k] = 1'b0;
                    m_left[k] = m_drain[k];
                end
            end else if (m_left[k] > 0) begin
                m_left[k]--;
            end else if (ex_valid && !pipe_stall && branch_jump != 3'b010) begin
                acc = 1'b1;
                if (pc_sel) begin
                    m_req[k] = 1'b1;
                    m_pc[k] = {target_pc[31:1], 1'b0};
                    m_mis[k] = target_pc[1];
                end
            end
            if (cnt_clr) begin
                m_tk[k] = 0;
                m_ntk[k] = 0;
            end else if (acc) begin
                if (pc_sel) m_tk[k] = (m_tk[k] < m_max[k]) ? m_tk[k] + 1 : m_tk[k];
                else        m_ntk[k] = (m_ntk[k] < m_max[k]) ? m_ntk[k] + 1 : m_ntk[k];
            end
        end
    endtask

    task automatic compare_all();
        bit busy;
        for (int k = 0; k < 2; k++) begin
            busy = m_req[k] || (m_left[k] > 0);
            chk($sformatf("rv%0d", k),     o_rv[k],   32'(m_req[k]));
            chk($sformatf("pc%0d", k),     o_pc[k],   m_pc[k]);
            chk($sformatf("fif%0d", k),    o_fif[k],  32'(busy));
            chk($sformatf("fie%0d", k),    o_fie[k],  32'(m_req[k]));
            chk($sformatf("hold%0d", k),   o_hold[k], 32'(busy));
            chk($sformatf("mis%0d", k),    o_mis[k],  32'(m_mis[k]));
            chk($sformatf("taken%0d", k),  o_tk[k],   m_tk[k]);
            chk($sformatf("ntaken%0d", k), o_ntk[k],  m_ntk[k]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit ev, input bit st, input logic [2:0] bj, input bit sel,
                         input logic [31:0] tgt, input bit rdy, input bit clr);
        ex_valid = ev; pipe_stall = st; branch_jump = bj; pc_sel = sel;
        target_pc = tgt; if_ready = rdy; cnt_clr = clr;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 3'b010, 0, 32'h0, 1, 0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        model_reset();
        // Reset values
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("rst_rv", o_rv[0], 32'h0);
        chk("rst_tk", o_tk[1], 32'h0);

        // Taken BEQ to 0x104 with immediate handshake
        drive(1, 0, 3'b000, 1, 32'h0000_0104, 1, 0);
        cycle();
        chk("beq_rv", o_rv[0], 32'h1);
        chk("beq_pc", o_pc[0], 32'h104);
        drive(0, 0, 3'b010, 0, 32'h0, 1, 0);
        cycle();
        chk("beq_drain_rv", o_rv[0], 32'h0);
        chk("beq_drain_fif", o_fif[0], 32'h1);
        chk("beq_drain_fie", o_fie[0], 32'h0);
        cycle();
        chk("beq_idle_hold", o_hold[0], 32'h0);
        chk("beq_taken", o_tk[0], 32'h1);
        idle(3);

        // JAL to 0x2001 with fetch backpressure; EX branches meanwhile are ignored
        drive(1, 0, 3'b011, 1, 32'h0000_2001, 0, 0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 3'($urandom_range(0, 7)), 1'($urandom), $urandom, 0, 0);
            cycle();
            chk("bp_rv", o_rv[1], 32'h1);
            chk("bp_pc", o_pc[1], 32'h2000);
            chk("bp_tk", o_tk[0], 32'h2);
        end
        drive(0, 0, 3'b010, 0, 32'h0, 1, 0);
        cycle();
        chk("bp_done_rv", o_rv[1], 32'h0);
        idle(4);

        // Misaligned taken BLT still redirects
        drive(1, 0, 3'b100, 1, 32'h0000_0102, 0, 0);
        cycle();
        chk("mis_pulse", o_mis[0], 32'h1);
        chk("mis_pc", o_pc[0], 32'h102);
        drive(0, 0, 3'b010, 0, 32'h0, 1, 0);
        cycle();
        chk("mis_clear", o_mis[0], 32'h0);
        idle(4);

        // Filtering: class 010 and pipeline stall
        drive(1, 0, 3'b010, 1, 32'h0000_0300, 1, 0);
        cycle();
        chk("none_rv", o_rv[0], 32'h0);
        drive(1, 1, 3'b001, 1, 32'h0000_0200, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_rv", o_rv[1], 32'h0);
        end
        pipe_stall = 1'b0;
        cycle();
        chk("stall_then_rv", o_rv[1], 32'h1);
        idle(5);

        // Saturation on the 4-bit instance, then clear-vs-increment priority
        drive(0, 0, 3'b010, 0, 32'h0, 1, 1);
        cycle();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 3'b111, 0, 32'h0, 1, 0);
            cycle();
            chk("sat_a", o_ntk[0], (i + 1 < 15) ? 32'(i + 1) : 32'd15);
            chk("sat_b", o_ntk[1], 32'(i + 1));
        end
        drive(1, 0, 3'b111, 0, 32'h0, 1, 1);
        cycle();
        chk("clr_a", o_ntk[0], 32'h0);
        chk("clr_b", o_ntk[1], 32'h0);

        // Asynchronous reset in the middle of a redirect
        drive(1, 0, 3'b101, 1, 32'h0000_4000, 0, 0);
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("arst_rv", o_rv[0], 32'h0);
        chk("arst_hold", o_hold[1], 32'h0);
        idle(1);
        rst_n = 1'b1;
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0),
                  3'($urandom_range(0, 7)), 1'($urandom), $urandom,
                  1'($urandom), ($urandom_range(0, 40) == 0));
            rst_n = ($urandom_range(0, 299) != 0);
            cycle();
        end
        rst_n = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
